// File: rtl/add_offset_arbiter.sv
// Round-robin arbiter that shares one registered add-offset datapath among NUM_REQ requesters.
// Optional embedded assertions are enabled by defining ADD_OFFSET_ARBITER_ASSERT_EN.
module add_offset_arbiter #(
   parameter int unsigned      NUM_REQ = 4,
   parameter int unsigned      WIDTH   = 32,
   parameter logic [WIDTH-1:0] OFFSET  = WIDTH'(5),
   parameter int unsigned      ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [WIDTH-1:0]         resp_data,
   output logic [ID_W-1:0]          resp_id,
   output logic                     busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               resp_valid_q, resp_valid_d;
   logic [WIDTH-1:0]   resp_data_q, resp_data_d;
   logic [ID_W-1:0]    resp_id_q, resp_id_d;
   logic [WIDTH-1:0]   op_q, op_d;
   logic [ID_W-1:0]    id_q, id_d;

   logic               win_found;
   logic [ID_W-1:0]    win_id;
   int unsigned        idx;

   // Search upward from rr_ptr, wrapping at NUM_REQ-1, for the first active request.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(rr_ptr_q) + i) % NUM_REQ;
         if (!win_found && req[ID_W'(idx)]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         gnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_id_q    <= '0;
         op_q         <= '0;
         id_q         <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_q        <= gnt_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_id_q    <= resp_id_d;
         op_q         <= op_d;
         id_q         <= id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (win_found) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      gnt_d        = '0;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_id_d    = resp_id_q;
      op_d         = op_q;
      id_d         = id_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               op_d  = req_data[32'(win_id) * WIDTH +: WIDTH];
               id_d  = win_id;
               gnt_d = NUM_REQ'(1) << win_id;
            end
         end
         EXEC: begin
            resp_data_d  = op_q + OFFSET;
            resp_id_d    = id_q;
            resp_valid_d = 1'b1;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               rr_ptr_d     = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
            end
         end
         default: begin
            resp_valid_d = 1'b0;
         end
      endcase
   end

   assign gnt        = gnt_q;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_id    = resp_id_q;
   assign busy       = (state_q != IDLE);

`ifdef ADD_OFFSET_ARBITER_ASSERT_EN
   logic [NUM_REQ-1:0] req_prev;
   logic               stall_prev;
   logic [WIDTH-1:0]   data_prev;
   logic [ID_W-1:0]    id_prev;

   // History is cleared during reset so no check spans a reset edge.
   always_ff @(posedge clk) begin
      req_prev   <= rst ? '0 : req;
      stall_prev <= !rst && resp_valid_q && !resp_ready;
      data_prev  <= resp_data_q;
      id_prev    <= resp_id_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ($onehot0(gnt_q));
         assert (!resp_valid_q || (resp_data_q == op_q + OFFSET));
         assert (!stall_prev || ((resp_data_q == data_prev) && (resp_id_q == id_prev)));
         assert ((gnt_q & ~req_prev) == '0);
         assert (state_q inside {IDLE, EXEC, RESP});
      end
   end
`endif

endmodule

// File: tb/tb_add_offset_arbiter.sv
// Directed self-checking bench for add_offset_arbiter (NUM_REQ=4, WIDTH=32, OFFSET=5).
module tb_add_offset_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned ID_W    = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       gnt;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [WIDTH-1:0]         resp_data;
   logic [ID_W-1:0]          resp_id;
   logic                     busy;

   int checks   = 0;
   int failures = 0;

   add_offset_arbiter #(
      .NUM_REQ (NUM_REQ),
      .WIDTH   (WIDTH),
      .OFFSET  (32'd5),
      .ID_W    (ID_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int unsigned i, input logic [WIDTH-1:0] v);
      req_data[i*WIDTH +: WIDTH] = v;
   endtask

   initial begin
      rst        = 1'b1;
      req        = '0;
      req_data   = '0;
      resp_ready = 1'b1;
      tick();
      tick();

      check("rst_gnt",   64'(gnt), 64'h0);
      check("rst_valid", 64'(resp_valid), 64'h0);
      check("rst_data",  64'(resp_data), 64'h0);
      check("rst_id",    64'(resp_id), 64'h0);
      check("rst_busy",  64'(busy), 64'h0);
      rst = 1'b0;
      tick();

      // Single request
      req = 4'b0010;
      set_op(1, 32'd10);
      tick();
      check("single_gnt",  64'(gnt), 64'h2);
      check("single_busy", 64'(busy), 64'h1);
      req = '0;
      tick();
      check("single_gnt_clr", 64'(gnt), 64'h0);
      check("single_valid",   64'(resp_valid), 64'h1);
      check("single_data",    64'(resp_data), 64'd15);
      check("single_id",      64'(resp_id), 64'd1);
      tick();
      check("single_idle_valid", 64'(resp_valid), 64'h0);
      check("single_idle_busy",  64'(busy), 64'h0);

      // Round-robin with all requesters held high
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_op(0, 32'd0);
      set_op(1, 32'd100);
      set_op(2, 32'd200);
      set_op(3, 32'd300);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("rr_gnt%0d", k), 64'(gnt), 64'(4'b0001 << (k % 4)));
         tick();
         check($sformatf("rr_data%0d", k), 64'(resp_data), 64'((k % 4) * 100 + 5));
         check($sformatf("rr_id%0d", k), 64'(resp_id), 64'(k % 4));
         tick();
         check($sformatf("rr_idle%0d", k), 64'(busy), 64'h0);
      end
      req = '0;

      // Backpressure: last served was 0, only requester 0 asks again
      resp_ready = 1'b0;
      req = 4'b0001;
      set_op(0, 32'd7);
      tick();
      check("bp_gnt", 64'(gnt), 64'h1);
      req = '0;
      tick();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_valid%0d", k), 64'(resp_valid), 64'h1);
         check($sformatf("bp_data%0d", k),  64'(resp_data), 64'd12);
         check($sformatf("bp_id%0d", k),    64'(resp_id), 64'd0);
         check($sformatf("bp_gnt%0d", k),   64'(gnt), 64'h0);
         check($sformatf("bp_busy%0d", k),  64'(busy), 64'h1);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      check("bp_release_valid", 64'(resp_valid), 64'h0);
      check("bp_release_busy",  64'(busy), 64'h0);

      // Wrap-around of the adder
      req = 4'b0100;
      set_op(2, 32'hFFFF_FFFE);
      tick();
      check("wrap_gnt", 64'(gnt), 64'h4);
      req = '0;
      tick();
      check("wrap_data", 64'(resp_data), 64'h0000_0003);
      check("wrap_id",   64'(resp_id), 64'd2);
      tick();
      check("wrap_idle", 64'(busy), 64'h0);

      // Reset during EXEC aborts the operation
      req = 4'b0010;
      set_op(1, 32'd50);
      set_op(3, 32'd0);
      tick();
      check("abort_gnt", 64'(gnt), 64'h2);
      rst = 1'b1;
      req = 4'b1000;
      tick();
      check("abort_valid",  64'(resp_valid), 64'h0);
      check("abort_gnt0",   64'(gnt), 64'h0);
      check("abort_busy",   64'(busy), 64'h0);
      check("abort_data",   64'(resp_data), 64'h0);
      check("abort_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
      rst = 1'b0;
      tick();
      check("pend_gnt",      64'(gnt), 64'h8);
      check("pend_no_valid", 64'(resp_valid), 64'h0);
      req = '0;
      tick();
      check("pend_data", 64'(resp_data), 64'd5);
      check("pend_id",   64'(resp_id), 64'd3);
      tick();

      // Late request arriving during RESP waits for IDLE
      resp_ready = 1'b0;
      req = 4'b0001;
      set_op(0, 32'd1);
      tick();
      check("late_first_gnt", 64'(gnt), 64'h1);
      req = '0;
      tick();
      check("late_first_valid", 64'(resp_valid), 64'h1);
      req = 4'b0100;
      set_op(2, 32'd20);
      tick();
      check("late_hold_gnt_a", 64'(gnt), 64'h0);
      check("late_hold_valid", 64'(resp_valid), 64'h1);
      tick();
      check("late_hold_gnt_b", 64'(gnt), 64'h0);
      resp_ready = 1'b1;
      tick();
      check("late_idle_gnt",  64'(gnt), 64'h0);
      check("late_idle_busy", 64'(busy), 64'h0);
      tick();
      check("late_gnt", 64'(gnt), 64'h4);
      req = '0;
      tick();
      check("late_data", 64'(resp_data), 64'd25);
      check("late_id",   64'(resp_id), 64'd2);
      tick();
      check("late_end_busy", 64'(busy), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/add_offset_arbiter.md
Name: add_offset_arbiter

Overview:
- Shares one registered add-offset datapath (result = operand + OFFSET) among NUM_REQ requesters.
- Round-robin arbitration picks one request at a time.
- Latches the winner's operand and runs it through the shared adder. Returns the result tagged with the requester index over a valid/ready response channel.
- Sits between the requesting blocks and the single offset adder, which the controller sequences.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 32, operand/result width in bits
- OFFSET, 5, constant added by the shared datapath (WIDTH bits)
- ID_W, $clog2(NUM_REQ), width of requester index

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous active-high reset
- req  input  NUM_REQ  per-requester request, level
- req_data  input  NUM_REQ*WIDTH  packed operands; requester i at bits [i*WIDTH +: WIDTH]
- gnt  output  NUM_REQ  registered one-hot grant pulse, one cycle
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_data  output  WIDTH  operand + OFFSET
- resp_id  output  ID_W  index of requester that owns resp_data
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at posedge) sets:
  - state=IDLE, rr_ptr=0, gnt=0, resp_valid=0
  - resp_data=0, resp_id=0, busy=0, internal operand/id regs=0
- Reset mid-operation aborts the operation. No response is produced and no grant is re-issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner w: the first set bit of req searching upward from rst-free pointer rr_ptr, wrapping from NUM_REQ-1 to 0.
  - At the edge: op_reg<=req_data[w], id_reg<=w, gnt<=(1<<w), state<=EXEC.
- EXEC:
  - gnt<=0.
  - resp_data<=op_reg+OFFSET, truncated to WIDTH (wraps mod 2^WIDTH, no carry out).
  - resp_id<=id_reg, resp_valid<=1, state<=RESP.
- RESP:
  - resp_valid held high; resp_data and resp_id held stable.
  - On resp_ready=1 at a posedge: resp_valid<=0, rr_ptr<=(id_reg+1) mod NUM_REQ, state<=IDLE.
  - resp_ready=0 stalls indefinitely. No new arbitration happens while in RESP.
- Latency and throughput:
  - Grant pulse appears 1 cycle after the request is sampled.
  - resp_valid rises 2 cycles after the request is sampled.
  - Max throughput is one operation per 3 cycles when resp_ready is held high.
- Requester rules:
  - Hold req and req_data stable until gnt[i] is seen.
  - Operand is captured on the grant edge; changes after that are ignored.
  - Requester deasserts req in the cycle after its gnt. If req is still high in the next IDLE, it is treated as a new request.
  - A request withdrawn before grant is legal and is simply not served.
- Fairness: after serving i, requester i has lowest priority. With all requesters asserting continuously, the grant order is 0,1,2,...,NUM_REQ-1,0,...
- Simultaneous events: requests arriving during EXEC/RESP are only sampled in the next IDLE cycle.
- Invariants:
  - gnt is one-hot or zero.
  - resp_valid==1 exactly when state==RESP.
  - busy==(state!=IDLE).

Optional Feature:
- Macro: ADD_OFFSET_ARBITER_ASSERT_EN.
- Defined: embedded immediate/concurrent assertions are compiled in, checked every posedge when rst==0:
  - $onehot0(gnt)
  - resp_valid -> resp_data == (captured operand + OFFSET) mod 2^WIDTH
  - resp_valid && !resp_ready -> resp_data, resp_id stable next cycle
  - gnt[i] -> req[i] was high in the previous cycle
  - state in {IDLE, EXEC, RESP}
- Undefined: no assertion code is present. Functional behaviour is identical.

Test Plan:
- Single request: reset, then req=4'b0010, req_data[1]=32'd10, resp_ready=1 → gnt=4'b0010 at cycle+1; resp_valid=1, resp_data=15, resp_id=1 at cycle+2; back in IDLE at cycle+3.
- Round-robin: req=4'b1111 held, resp_ready=1, operands 0,100,200,300 → grants in order 0,1,2,3,0; results 5,105,205,305,5.
- Backpressure: one request, data 7, resp_ready=0 for 5 cycles → resp_valid, resp_data=12 and resp_id stay stable; gnt stays 0; busy=1. Raise resp_ready → IDLE the next cycle.
- Wrap-around: req_data=32'hFFFF_FFFE → resp_data=32'h0000_0003.
- Reset mid-operation: assert rst in EXEC → next cycle state IDLE, resp_valid=0, gnt=0, rr_ptr=0. No response is emitted. A pending req=4'b1000 is then granted normally.
- Late request during RESP: req[2] rises while resp_valid=1 and resp_ready=0 → no gnt until the first IDLE cycle. gnt[2] is pulsed one cycle after IDLE is entered.
